// File: rtl/mips_pkg.sv
// Shared definitions for the stream steering stage: default payload width,
// destination select encoding and the per-slot holding state.
package mips_pkg;

  // Default payload width of the demux datapath.
  localparam int DEMUX_DATA_W = 8;

  // Destination select encoding on in_sel.
  localparam logic DEMUX_SEL_A = 1'b0;
  localparam logic DEMUX_SEL_B = 1'b1;

  // Occupancy of a one-entry holding slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : mips_pkg

// File: rtl/demux_out_slot.sv
// One-entry holding register with valid/ready on its consumer side.
// A new beat may be loaded while the current one drains in the same cycle,
// which gives full throughput. out_valid_o is a direct decode of the state
// register, so it doubles as the FSM state observation point.
module demux_out_slot
  import mips_pkg::*;
#(
  parameter int DATA_LENGTH = DEMUX_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [DATA_LENGTH-1:0] data_in_i,
  output logic                   can_take_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_LENGTH-1:0] out_data_o
);

  slot_state_e            state_q;
  logic [DATA_LENGTH-1:0] data_q;

  // Slot FSM and payload register; payload changes only when a beat is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (load_i) begin
            state_q <= SLOT_FULL;
            data_q  <= data_in_i;
          end
        end
        SLOT_FULL: begin
          if (load_i) begin
            data_q <= data_in_i;
          end else if (out_ready_i) begin
            state_q <= SLOT_EMPTY;
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign can_take_o  = (state_q == SLOT_EMPTY) | out_ready_i;
  assign out_valid_o = (state_q == SLOT_FULL);
  assign out_data_o  = data_q;

endmodule : demux_out_slot

// File: rtl/stream_demux.sv
// 1-to-2 valid/ready steering stage: in_sel routes each accepted beat into
// slot A or slot B, each of which holds it until its consumer takes it.
// Handshake: a beat transfers on any edge where valid and ready are both 1;
// in_ready depends only on in_sel and the selected slot (never on in_valid),
// and a producer holds valid/data stable until the transfer happens.
// Optional feature macro STREAM_DEMUX_PERF_CNT_EN adds saturating per-port
// delivery counters cnt_a/cnt_b; without it those ports do not exist.
module stream_demux
  import mips_pkg::*;
#(
  parameter int DATA_LENGTH = DEMUX_DATA_W
`ifdef STREAM_DEMUX_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sel,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic                   out_a_valid,
  input  logic                   out_a_ready,
  output logic [DATA_LENGTH-1:0] out_a_data,
  output logic                   out_b_valid,
  input  logic                   out_b_ready,
  output logic [DATA_LENGTH-1:0] out_b_data
`ifdef STREAM_DEMUX_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   cnt_a,
  output logic [CNT_WIDTH-1:0]   cnt_b
`endif
);

  logic a_can_take;
  logic b_can_take;
  logic accept;
  logic load_a;
  logic load_b;

  // Only the selected slot gates acceptance, so a stall on the other port never blocks.
  always_comb begin
    in_ready = (in_sel == DEMUX_SEL_B) ? b_can_take : a_can_take;
    accept   = in_valid & in_ready;
    load_a   = accept & (in_sel == DEMUX_SEL_A);
    load_b   = accept & (in_sel == DEMUX_SEL_B);
  end

  demux_out_slot #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_slot_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_a),
    .data_in_i   (in_data),
    .can_take_o  (a_can_take),
    .out_valid_o (out_a_valid),
    .out_ready_i (out_a_ready),
    .out_data_o  (out_a_data)
  );

  demux_out_slot #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_slot_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_b),
    .data_in_i   (in_data),
    .can_take_o  (b_can_take),
    .out_valid_o (out_b_valid),
    .out_ready_i (out_b_ready),
    .out_data_o  (out_b_data)
  );

`ifdef STREAM_DEMUX_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;

  // Next counts: add one per delivered beat, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (out_a_valid && out_a_ready && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
    if (out_b_valid && out_b_ready && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
  end

  // Delivery counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: reset, steering, per-port backpressure,
// drain+load on one slot, back-to-back order, mid-traffic reset and (with
// STREAM_DEMUX_PERF_CNT_EN) saturating delivery counters.
module tb_stream_demux;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sel;
  logic [DW-1:0] in_data;
  logic          out_a_valid;
  logic          out_a_ready;
  logic [DW-1:0] out_a_data;
  logic          out_b_valid;
  logic          out_b_ready;
  logic [DW-1:0] out_b_data;
`ifdef STREAM_DEMUX_PERF_CNT_EN
  logic [1:0]    cnt_a;
  logic [1:0]    cnt_b;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_demux #(
    .DATA_LENGTH (DW)
`ifdef STREAM_DEMUX_PERF_CNT_EN
    ,
    .CNT_WIDTH   (2)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_data     (in_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_a_data  (out_a_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .out_b_data  (out_b_data)
`ifdef STREAM_DEMUX_PERF_CNT_EN
    ,
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
`endif
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic sel, input logic [DW-1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    check_eq("rst_a_valid", 32'(out_a_valid), 32'd0);
    check_eq("rst_b_valid", 32'(out_b_valid), 32'd0);
    check_eq("rst_a_data",  32'(out_a_data),  32'd0);
    check_eq("rst_b_data",  32'(out_b_data),  32'd0);
    check_eq("rst_in_ready", 32'(in_ready),   32'd1);

    // Steering: 0x11 -> A, then 0x22 -> B
    drive_beat(1'b0, 8'h11);
    tick();
    check_eq("steer_a_valid", 32'(out_a_valid), 32'd1);
    check_eq("steer_a_data",  32'(out_a_data),  32'h11);
    check_eq("steer_b_idle",  32'(out_b_valid), 32'd0);
    drive_beat(1'b1, 8'h22);
    #1;
    check_eq("steer_in_ready_b", 32'(in_ready), 32'd1);
    tick();
    check_eq("steer_a_one_cycle", 32'(out_a_valid), 32'd0);
    check_eq("steer_b_valid", 32'(out_b_valid), 32'd1);
    check_eq("steer_b_data",  32'(out_b_data),  32'h22);
    drive_idle();
    tick();
    check_eq("steer_b_one_cycle", 32'(out_b_valid), 32'd0);

    // Backpressure isolation: A stalled and full
    out_a_ready = 1'b0;
    drive_beat(1'b0, 8'h66);
    tick();
    check_eq("bp_a_full", 32'(out_a_valid), 32'd1);
    drive_beat(1'b0, 8'h77);
    #1;
    check_eq("bp_in_ready_a_blocked", 32'(in_ready), 32'd0);
    tick();
    check_eq("bp_a_valid_hold", 32'(out_a_valid), 32'd1);
    check_eq("bp_a_data_hold",  32'(out_a_data),  32'h66);
    drive_beat(1'b1, 8'h33);
    #1;
    check_eq("bp_in_ready_b_open", 32'(in_ready), 32'd1);
    tick();
    check_eq("bp_b_valid", 32'(out_b_valid), 32'd1);
    check_eq("bp_b_data",  32'(out_b_data),  32'h33);
    check_eq("bp_a_data_still", 32'(out_a_data), 32'h66);

    // Drain+load on slot A: 0x44 replaces 0x66, then 0x55 replaces 0x44
    out_a_ready = 1'b1;
    drive_beat(1'b0, 8'h44);
    #1;
    check_eq("dl_in_ready_44", 32'(in_ready), 32'd1);
    tick();
    check_eq("dl_a_data_44", 32'(out_a_data), 32'h44);
    check_eq("dl_b_drained", 32'(out_b_valid), 32'd0);
    drive_beat(1'b0, 8'h55);
    #1;
    check_eq("dl_in_ready_55", 32'(in_ready), 32'd1);
    tick();
    check_eq("dl_a_valid_stays", 32'(out_a_valid), 32'd1);
    check_eq("dl_a_data_55",     32'(out_a_data),  32'h55);
    drive_idle();
    tick();
    check_eq("dl_a_empty", 32'(out_a_valid), 32'd0);

    // Throughput/order: 0..7 back-to-back into B
    for (int i = 0; i < 8; i++) begin
      drive_beat(1'b1, DW'(i));
      exp_q.push_back(DW'(i));
      #1;
      check_eq("tp_in_ready", 32'(in_ready), 32'd1);
      tick();
      check_eq("tp_b_valid", 32'(out_b_valid), 32'd1);
      if (exp_q.size() > 0) check_eq("tp_b_data", 32'(out_b_data), 32'(exp_q.pop_front()));
    end
    drive_idle();
    tick();
    check_eq("tp_b_done", 32'(out_b_valid), 32'd0);
    check_eq("tp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Mid-traffic reset with A holding 0x5A
    out_a_ready = 1'b0;
    drive_beat(1'b0, 8'h5A);
    tick();
    drive_idle();
    check_eq("mr_a_full", 32'(out_a_valid), 32'd1);
    check_eq("mr_a_data", 32'(out_a_data),  32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_a_valid_async", 32'(out_a_valid), 32'd0);
    check_eq("mr_a_data_async",  32'(out_a_data),  32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("mr_post_a_valid", 32'(out_a_valid), 32'd0);
    check_eq("mr_post_b_valid", 32'(out_b_valid), 32'd0);
    check_eq("mr_post_a_data",  32'(out_a_data),  32'd0);
    check_eq("mr_post_b_data",  32'(out_b_data),  32'd0);

    // Five deliveries on A (counters saturate at 3 with a 2-bit width)
    out_a_ready = 1'b1;
`ifdef STREAM_DEMUX_PERF_CNT_EN
    check_eq("cnt_a_reset", 32'(cnt_a), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      drive_beat(1'b0, DW'(8'hA0 + i));
      tick();
      check_eq("cnt_run_a_data", 32'(out_a_data), 32'(8'hA0 + i));
    end
    drive_idle();
    tick();
    check_eq("cnt_run_a_empty", 32'(out_a_valid), 32'd0);
`ifdef STREAM_DEMUX_PERF_CNT_EN
    check_eq("cnt_a_saturated", 32'(cnt_a), 32'd3);
    check_eq("cnt_b_zero",      32'(cnt_b), 32'd0);
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stream_demux
